t01_keyscan: RTL
================

# t01_keyscan

Matrix keypad scanner for the 20-key (4 rows x 5 columns) keypad. Drives one column at a time, samples the row lines through a two-flop synchronizer, debounces the full 20-bit key image over several scan frames, and reports a press as a one-cycle `key_valid` pulse with a 5-bit key code. It sits on the pad side of the keypad input path and replaces raw per-key lines with a clean, debounced key image and press event for the downstream calculator logic.

## Interface
- `SCAN_DIV`, 4: cycles each column is driven; legal range 3..255.
- `DEBOUNCE`, 3: consecutive identical frames required to accept a new image; legal range 1..15.

- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `row_in`  in  4  keypad row lines, active-high, asynchronous to `clk`.
- `col_out`  out  5  column drive, one-hot, active-high.
- `keys`  out  20  debounced key image; bit index = row*5 + col.
- `key_code`  out  5  index of highest set bit of `keys` at the last press event.
- `key_valid`  out  1  one-cycle press strobe.
- `key_held`  out  1  high while `keys` is non-zero.

## Operation
- Reset values: `col_out`=5'b00001, `keys`=0, `key_code`=0, `key_valid`=0, `key_held`=0. The synchronizer, counters, frame buffer and stable count all clear.
- Synchronizer: `row_in` passes through two flops (`row_s`) before any use.
- Column sequencer:
  - A divider counts 0..SCAN_DIV-1.
  - On terminal count, `col_out` rotates left one position, wrapping from 5'b10000 to 5'b00001.
- Sampling:
  - On the divider terminal count, `row_s` is written into the frame buffer bits {row*5+col} of the current column.
  - Sampling happens in the same cycle the column advances, so sampled data reflects the column driven for the full period minus the 2-cycle synchronizer delay.
- Frame completion: the sample of column 4 completes a 20-bit frame. The frame is compared with the previous completed frame:
  - If equal, the stable count increments and saturates at DEBOUNCE.
  - If different, the stable count is set to 1 and the previous frame is replaced.
  - When the stable count reaches DEBOUNCE and the frame differs from `keys`, `keys` loads the frame in the next cycle.
- Press event:
  - Fires when `keys` goes from zero to non-zero.
  - In the same cycle `keys` updates, `key_valid` pulses for one cycle and `key_code` loads the highest set index of the new image.
  - Changes from one non-zero image to another non-zero image, such as adding or releasing a second key while one is held, update `keys` only. They produce no `key_valid` and leave `key_code` unchanged.
- Release: `keys` returns to zero after DEBOUNCE identical all-zero frames. `key_held` falls with it, and `key_code` holds its last value.
- `key_held` = |`keys`, registered alongside `keys`.
- Reset mid-frame: all state clears immediately and scanning restarts at column 0, divider 0. No `key_valid` fires during or right after reset.

## Timing
- Frame period = 5*SCAN_DIV cycles.
- Press latency, from a stable `row_in` at the first fully sampled frame to `key_valid`: DEBOUNCE frames + 1 cycle. Worst case adds one partial frame for the point in the scan where the press lands.
- Glitches shorter than one frame never reach `keys` when DEBOUNCE ≥ 2.
- With DEBOUNCE=1, any frame that differs from `keys` is accepted after one frame.
- `key_valid` is never high for two consecutive cycles. The minimum spacing between pulses is (2*DEBOUNCE) frames: one release interval plus one press interval.

## Test plan
- Reset release with SCAN_DIV=4:
  - `col_out` sequence: 00001 for cycles 0-3, 00010 for 4-7, …, 10000 for 16-19, then 00001 again at cycle 20.
  - All other outputs stay 0.
- Hold row 2 high only while column 3 is driven (steady key 13), with DEBOUNCE=3:
  - `keys`=20'h02000.
  - `key_valid` pulses once with `key_code`=13.
  - `key_held`=1.
  - Release the key: after 3 all-zero frames `keys`=0, `key_held`=0, and `key_code` stays 13.
- Bounce: toggle key 7 for 1 frame, then zero → no change in `keys` and no `key_valid`.
- Two keys:
  - Press key 4, wait for `key_valid` (`key_code`=4), then add key 18.
  - `keys`=bits 4 and 18, with no second `key_valid` and `key_code` staying 4.
  - Release both, then press 4 and 18 together → `key_valid` with `key_code`=18.
- Assert `nrst` mid-frame while key 0 is debounced:
  - `keys`=0, `key_held`=0, `col_out`=00001 immediately.
  - After release, holding key 0 gives a fresh `key_valid` after 3 frames.
- `row_in` toggling asynchronously at half the `clk` rate while no column matches → `keys` stays 0 and no `key_valid`.

Source files
------------

// File: rtl/t01_keyscan_if.sv
// Keypad-side bundle for t01_keyscan: column drive, row sense and the
// debounced key image/event outputs handed to downstream logic.
interface t01_keyscan_if;
   logic [3:0]  row_in;
   logic [4:0]  col_out;
   logic [19:0] keys;
   logic [4:0]  key_code;
   logic        key_valid;
   logic        key_held;

   modport master (
      output row_in,
      input  col_out, keys, key_code, key_valid, key_held
   );

   modport slave (
      input  row_in,
      output col_out, keys, key_code, key_valid, key_held
   );
endinterface

// File: rtl/t01_keyscan.sv
// 4x5 matrix keypad scanner: column sequencer, row synchronizer, frame-level
// debounce of the 20-bit key image and a one-cycle press strobe with key code.
module t01_keyscan #(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned DEBOUNCE = 3
) (
   input logic         clk,
   input logic         nrst,
   t01_keyscan_if.slave kif
);

   logic [3:0]  row_m_q, row_s_q;
   logic [7:0]  div_q, div_d;
   logic [4:0]  col_q, col_d;
   logic [19:0] frame_q, frame_d;
   logic [19:0] prev_q, prev_d;
   logic [3:0]  stable_q, stable_d;
   logic        load_q, load_d;
   logic [19:0] keys_q, keys_d;
   logic [4:0]  code_q, code_d;
   logic        valid_q, valid_d;
   logic        held_q, held_d;

   logic        tc;
   logic        frame_done;
   logic [19:0] sample;
   logic [4:0]  hi_idx;

   assign tc         = (div_q == 8'(SCAN_DIV - 1));
   assign frame_done = tc && col_q[4];

   always_comb begin
      div_d = tc ? '0 : div_q + 8'd1;
      col_d = tc ? {col_q[3:0], col_q[4]} : col_q;
   end

   // Row data lands in the bits of whichever column is currently driven.
   always_comb begin
      sample = frame_q;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 5; c++) begin
            if (col_q[c]) sample[r*5 + c] = row_s_q[r];
         end
      end
      frame_d = tc ? sample : frame_q;
   end

   always_comb begin
      prev_d   = prev_q;
      stable_d = stable_q;
      load_d   = 1'b0;
      if (frame_done) begin
         if (sample == prev_q) begin
            if (stable_q < 4'(DEBOUNCE)) stable_d = stable_q + 4'd1;
         end else begin
            stable_d = 4'd1;
            prev_d   = sample;
         end
         load_d = (stable_d == 4'(DEBOUNCE)) && (sample != keys_q);
      end
   end

   always_comb begin
      hi_idx = '0;
      for (int unsigned i = 0; i < 20; i++) begin
         if (prev_q[i]) hi_idx = 5'(i);
      end
   end

   // prev_q holds the accepted frame during the cycle after frame completion.
   always_comb begin
      keys_d  = keys_q;
      held_d  = held_q;
      code_d  = code_q;
      valid_d = 1'b0;
      if (load_q) begin
         keys_d = prev_q;
         held_d = |prev_q;
         if ((keys_q == '0) && (prev_q != '0)) begin
            valid_d = 1'b1;
            code_d  = hi_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         row_m_q  <= '0;
         row_s_q  <= '0;
         div_q    <= '0;
         col_q    <= 5'b00001;
         frame_q  <= '0;
         prev_q   <= '0;
         stable_q <= '0;
         load_q   <= 1'b0;
         keys_q   <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         row_m_q  <= kif.row_in;
         row_s_q  <= row_m_q;
         div_q    <= div_d;
         col_q    <= col_d;
         frame_q  <= frame_d;
         prev_q   <= prev_d;
         stable_q <= stable_d;
         load_q   <= load_d;
         keys_q   <= keys_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         held_q   <= held_d;
      end
   end

   assign kif.col_out   = col_q;
   assign kif.keys      = keys_q;
   assign kif.key_code  = code_q;
   assign kif.key_valid = valid_q;
   assign kif.key_held  = held_q;

endmodule
